uart_stream_ctrl: RTL

UART_STREAM_CTRL -- requirements
Module: uart_stream_ctrl

---
 rtl/uart_stream_ctrl_if.sv | 23 ++
 rtl/uart_stream_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/uart_stream_ctrl_if.sv
// Handshake bundle between the stream controller and the UART core.
interface uart_stream_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Rx_Data;
  logic              Rx_Ready;
  logic              Rx_Ack;
  logic [DATA_W-1:0] Tx_Data;
  logic              Tx_Send;
  logic              Tx_Busy;

  // Controller side: consumes RX, produces TX requests.
  modport master (
    input  Rx_Data, Rx_Ready, Tx_Busy,
    output Rx_Ack, Tx_Data, Tx_Send
  );

  // UART core side.
  modport slave (
    output Rx_Data, Rx_Ready, Tx_Busy,
    input  Rx_Ack, Tx_Data, Tx_Send
  );
endinterface

// File: rtl/uart_stream_ctrl.sv
// UART stream controller: pattern generator (Mode 0) or RX->TX echo via FIFO (Mode 1).
module uart_stream_ctrl #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] FIRST_CHAR = DATA_W'('h41),
  parameter logic [DATA_W-1:0] LAST_CHAR  = DATA_W'('h5A),
  parameter int                GAP_CYCLES = 0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          Mode,
  uart_stream_ctrl_if.master            uart,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  // A zero gap still costs one GAP cycle.
  localparam int GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, pat_q;
  logic [GW-1:0]     gap_cnt_q;
  logic              rx_ack_q, ovf_q, mode_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;

  logic flush, load, pop, push, full, wr_ok, drop, advance;

  // Next-state logic; a Mode change seen in IDLE flushes instead of sending.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Mode != mode_q) flush = 1'b1;
        else if (Enable && (!mode_q || cnt_q != '0)) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND:    if (uart.Tx_Busy) state_d = WAIT;
      WAIT:    if (!uart.Tx_Busy) state_d = GAP;
      GAP:     if (gap_cnt_q == GW'(GAP_LEN - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop     = load && mode_q;
  assign advance = (state_q == WAIT) && !uart.Tx_Busy && !mode_q;
  // A character is taken on the edge that raises Rx_Ack; only echo mode keeps it.
  assign push    = uart.Rx_Ready && !rx_ack_q && mode_q && !flush;
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_ok   = push && (!full || pop);
  assign drop    = push && full && !pop;

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: FIFO bookkeeping, pattern counter, gap timer, RX ack, TX data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tx_data_q <= FIRST_CHAR;
      pat_q     <= FIRST_CHAR;
      gap_cnt_q <= '0;
      rx_ack_q  <= 1'b0;
      ovf_q     <= 1'b0;
      mode_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      // 4-phase ack is simply Rx_Ready delayed by one cycle.
      rx_ack_q <= uart.Rx_Ready;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        pat_q    <= FIRST_CHAR;
        mode_q   <= Mode;
      end else begin
        if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        if (wr_ok && !pop)      cnt_q <= cnt_q + CW'(1);
        else if (!wr_ok && pop) cnt_q <= cnt_q - CW'(1);
        if (drop) ovf_q <= 1'b1;
        if (advance) pat_q <= (pat_q == LAST_CHAR) ? FIRST_CHAR : pat_q + 1'b1;
      end
      if (load) tx_data_q <= mode_q ? mem[rd_ptr_q] : pat_q;
      if (state_q == WAIT)     gap_cnt_q <= '0;
      else if (state_q == GAP) gap_cnt_q <= gap_cnt_q + 1'b1;
    end
  end

  // FIFO storage; a full write with a same-cycle pop reuses the slot being read.
  always_ff @(posedge Clk) begin
    if (wr_ok && !Reset) mem[wr_ptr_q] <= uart.Rx_Data;
  end

  assign uart.Rx_Ack  = rx_ack_q;
  assign uart.Tx_Data = tx_data_q;
  assign uart.Tx_Send = (state_q == SEND);
  assign Overflow     = ovf_q;
  assign Fifo_Count   = cnt_q;
endmodule
